// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Merges two register-file writeback streams onto a single write port.
// Requester 0 is the ALU writeback and requester 1 is the load writeback.
// When both request in the same cycle, a one-bit priority pointer picks the
// winner and then flips, so neither stream can starve. The accepted write
// reaches the register file one cycle later. Writes to register 0 complete
// the handshake but never assert the write enable.
//
// Optional feature, enabled by defining macro RF_SCOREBOARD_EN:
//   A 32-entry busy scoreboard. A destination is marked busy when it is
//   reserved at issue, and cleared on the edge after its register-file write.
//   Without the macro the busy outputs are tied to 0.
//
// Parameters
//   START_PRIO  requester (0 or 1) that holds priority after reset
//
// Ports
//   clk                  clock, rising edge
//   resetn               asynchronous reset, active low
//   s0_valid / s1_valid  write request valid
//   s0_waddr / s1_waddr  destination register number
//   s0_wdata / s1_wdata  write data
//   s0_ready / s1_ready  request accepted this cycle (combinational)
//   rf_wen               register-file write enable (registered)
//   rf_waddr             register-file write address (registered)
//   rf_wdata             register-file write data (registered)
//   rsv_valid, rsv_addr  destination reservation at issue
//   chk_addr1/2          source-operand addresses to look up
//   chk_busy1/2          source operand is still awaiting its writeback

module rf_wb_arbiter #(
  parameter int START_PRIO = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_valid,
  input  logic [4:0]  s0_waddr,
  input  logic [31:0] s0_wdata,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [4:0]  s1_waddr,
  input  logic [31:0] s1_wdata,
  output logic        s1_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2
);

  typedef enum logic {
    PRIO_S0 = 1'b0,
    PRIO_S1 = 1'b1
  } prio_e;

  localparam prio_e PRIO_RESET = (START_PRIO != 0) ? PRIO_S1 : PRIO_S0;

  prio_e       prio_q;
  prio_e       prio_d;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [4:0]  acc_waddr;
  logic [31:0] acc_wdata;

  // Priority pointer register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q <= PRIO_RESET;
    end else begin
      prio_q <= prio_d;
    end
  end

  // The pointer only moves when both requesters contend: the holder wins
  // and priority passes to the other one. Uncontended grants leave it alone.
  always_comb begin
    prio_d = prio_q;
    if (s0_valid && s1_valid) begin
      prio_d = (prio_q == PRIO_S0) ? PRIO_S1 : PRIO_S0;
    end
  end

  // Grant decode. Gating with resetn keeps both readies low while reset is
  // held, so requests outstanding during reset are never accepted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (resetn) begin
      if (s0_valid && s1_valid) begin
        grant0 = (prio_q == PRIO_S0);
        grant1 = (prio_q == PRIO_S1);
      end else begin
        grant0 = s0_valid;
        grant1 = s1_valid;
      end
    end
  end

  assign s0_ready  = grant0;
  assign s1_ready  = grant1;
  assign accept    = grant0 | grant1;
  assign acc_waddr = grant1 ? s1_waddr : s0_waddr;
  assign acc_wdata = grant1 ? s1_wdata : s0_wdata;

  // Output stage. Address and data only update on a real write, so they
  // hold their last values whenever rf_wen is low (including writes to x0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (accept && (acc_waddr != 5'd0)) begin
      rf_wen   <= 1'b1;
      rf_waddr <= acc_waddr;
      rf_wdata <= acc_wdata;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // The clear is applied before the set so that a reservation landing on
  // the same edge as the old write's clear leaves the register busy.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      set_mask = 32'd1 << rsv_addr;
    end
    if (rf_wen) begin
      clr_mask = 32'd1 << rf_waddr;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign chk_busy1 = (chk_addr1 != 5'd0) && busy_q[chk_addr1];
  assign chk_busy2 = (chk_addr2 != 5'd0) && busy_q[chk_addr2];
`else
  logic unused_sb;

  // Without the scoreboard the reservation and lookup inputs are ignored.
  assign unused_sb = ^{rsv_valid, rsv_addr, chk_addr1, chk_addr2};
  assign chk_busy1 = 1'b0;
  assign chk_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model. Optional
// scoreboard checks follow macro RF_SCOREBOARD_EN.

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s0_valid;
  logic [4:0]  s0_waddr;
  logic [31:0] s0_wdata;
  logic        s0_ready;
  logic        s1_valid;
  logic [4:0]  s1_waddr;
  logic [31:0] s1_wdata;
  logic        s1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;

  int nchecks = 0;
  int nerrors = 0;

  rf_wb_arbiter #(.START_PRIO(0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s0_valid  (s0_valid),
    .s0_waddr  (s0_waddr),
    .s0_wdata  (s0_wdata),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_waddr  (s1_waddr),
    .s1_wdata  (s1_wdata),
    .s1_ready  (s1_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task drive_idle();
    s0_valid  = 1'b0;
    s0_waddr  = 5'd0;
    s0_wdata  = 32'd0;
    s1_valid  = 1'b0;
    s1_waddr  = 5'd0;
    s1_wdata  = 32'd0;
    rsv_valid = 1'b0;
    rsv_addr  = 5'd0;
    chk_addr1 = 5'd0;
    chk_addr2 = 5'd0;
  endtask

  // Holds reset for two edges and releases it 1 unit after an edge.
  task apply_reset();
    resetn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Outputs while reset is held, with requests and a reservation pending.
  task test_reset();
    resetn    = 1'b0;
    drive_idle();
    s0_valid  = 1'b1; s0_waddr = 5'd3; s0_wdata = 32'hAAAA_0003;
    s1_valid  = 1'b1; s1_waddr = 5'd4; s1_wdata = 32'hBBBB_0004;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    chk_addr1 = 5'd3; chk_addr2 = 5'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchecks++; if (s0_ready !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_s0_ready: got %0b expected 0", s0_ready); end
    nchecks++; if (s1_ready !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_s1_ready: got %0b expected 0", s1_ready); end
    nchecks++; if (rf_wen !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_rf_wen: got %0b expected 0", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd0) begin nerrors++; $display("[TB] FAIL reset_rf_waddr: got %0h expected 0", rf_waddr); end
    nchecks++; if (rf_wdata !== 32'd0) begin nerrors++; $display("[TB] FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
    nchecks++; if (chk_busy1 !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_chk_busy1: got %0b expected 0", chk_busy1); end
    nchecks++; if (chk_busy2 !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_chk_busy2: got %0b expected 0", chk_busy2); end
    drive_idle();
  endtask

  // Reset release followed by a single uncontended write.
  task test_single();
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    s0_valid = 1'b1; s0_waddr = 5'd5; s0_wdata = 32'h1111_1111;
    @(negedge clk);
    nchecks++; if (s0_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL single_s0_ready: got %0b expected 1", s0_ready); end
    nchecks++; if (s1_ready !== 1'b0) begin nerrors++; $display("[TB] FAIL single_s1_ready: got %0b expected 0", s1_ready); end
    @(posedge clk);
    #1;
    s0_valid = 1'b0;
    nchecks++; if (rf_wen !== 1'b1) begin nerrors++; $display("[TB] FAIL single_rf_wen: got %0b expected 1", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd5) begin nerrors++; $display("[TB] FAIL single_rf_waddr: got %0h expected 5", rf_waddr); end
    nchecks++; if (rf_wdata !== 32'h1111_1111) begin nerrors++; $display("[TB] FAIL single_rf_wdata: got %0h expected 11111111", rf_wdata); end
    @(posedge clk);
    #1;
    nchecks++; if (rf_wen !== 1'b0) begin nerrors++; $display("[TB] FAIL single_rf_wen_drop: got %0b expected 0", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd5) begin nerrors++; $display("[TB] FAIL single_rf_waddr_hold: got %0h expected 5", rf_waddr); end
    nchecks++; if (rf_wdata !== 32'h1111_1111) begin nerrors++; $display("[TB] FAIL single_rf_wdata_hold: got %0h expected 11111111", rf_wdata); end
  endtask

  // Three cycles of contention from a fresh reset: grants s0, s1, s0.
  task test_contention();
    logic [4:0] exp_addr [3];
    int         exp_grant [3];
    exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0;
    exp_addr[0]  = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd1;
    apply_reset();
    s0_valid = 1'b1; s0_waddr = 5'd1; s0_wdata = 32'hA0A0_0001;
    s1_valid = 1'b1; s1_waddr = 5'd2; s1_wdata = 32'hB0B0_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nchecks++; if (s0_ready !== (exp_grant[k] == 0)) begin nerrors++; $display("[TB] FAIL contend_s0_ready[%0d]: got %0b expected %0b", k, s0_ready, exp_grant[k] == 0); end
      nchecks++; if (s1_ready !== (exp_grant[k] == 1)) begin nerrors++; $display("[TB] FAIL contend_s1_ready[%0d]: got %0b expected %0b", k, s1_ready, exp_grant[k] == 1); end
      @(posedge clk);
      #1;
      nchecks++; if (rf_wen !== 1'b1) begin nerrors++; $display("[TB] FAIL contend_rf_wen[%0d]: got %0b expected 1", k, rf_wen); end
      nchecks++; if (rf_waddr !== exp_addr[k]) begin nerrors++; $display("[TB] FAIL contend_rf_waddr[%0d]: got %0h expected %0h", k, rf_waddr, exp_addr[k]); end
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  // Write to register 0: handshake completes, no register-file write.
  task test_reg0();
    s1_valid = 1'b1; s1_waddr = 5'd0; s1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    nchecks++; if (s1_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL reg0_s1_ready: got %0b expected 1", s1_ready); end
    @(posedge clk);
    #1;
    s1_valid = 1'b0;
    nchecks++; if (rf_wen !== 1'b0) begin nerrors++; $display("[TB] FAIL reg0_rf_wen: got %0b expected 0", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd1) begin nerrors++; $display("[TB] FAIL reg0_rf_waddr: got %0h expected 1", rf_waddr); end
    nchecks++; if (rf_wdata !== 32'hA0A0_0001) begin nerrors++; $display("[TB] FAIL reg0_rf_wdata: got %0h expected a0a00001", rf_wdata); end
  endtask

  // Reset pulsed while an accepted write sits in the output stage.
  task test_mid_reset();
    s0_valid = 1'b1; s0_waddr = 5'd7; s0_wdata = 32'h7777_7777;
    @(negedge clk);
    nchecks++; if (s0_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL midrst_s0_ready: got %0b expected 1", s0_ready); end
    @(posedge clk);
    #1;
    nchecks++; if (rf_wen !== 1'b1) begin nerrors++; $display("[TB] FAIL midrst_rf_wen_pre: got %0b expected 1", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd7) begin nerrors++; $display("[TB] FAIL midrst_rf_waddr_pre: got %0h expected 7", rf_waddr); end
    s1_valid = 1'b1; s1_waddr = 5'd8; s1_wdata = 32'h8888_8888;
    #1;
    resetn = 1'b0;
    #1;
    nchecks++; if (rf_wen !== 1'b0) begin nerrors++; $display("[TB] FAIL midrst_rf_wen: got %0b expected 0", rf_wen); end
    nchecks++; if (rf_waddr !== 5'd0) begin nerrors++; $display("[TB] FAIL midrst_rf_waddr: got %0h expected 0", rf_waddr); end
    nchecks++; if (rf_wdata !== 32'd0) begin nerrors++; $display("[TB] FAIL midrst_rf_wdata: got %0h expected 0", rf_wdata); end
    nchecks++; if ((s0_ready | s1_ready) !== 1'b0) begin nerrors++; $display("[TB] FAIL midrst_ready: got %0b%0b expected 00", s1_ready, s0_ready); end
    @(posedge clk);
    #1;
    nchecks++; if (rf_wen !== 1'b0) begin nerrors++; $display("[TB] FAIL midrst_rf_wen_held: got %0b expected 0", rf_wen); end
    drive_idle();
    resetn = 1'b1;
  endtask

`ifdef RF_SCOREBOARD_EN
  // Reserve, write back, and a reservation landing on the clearing edge.
  task test_scoreboard();
    apply_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(posedge clk);
    #1;
    rsv_valid = 1'b0;
    chk_addr1 = 5'd9; chk_addr2 = 5'd0;
    #1;
    nchecks++; if (chk_busy1 !== 1'b1) begin nerrors++; $display("[TB] FAIL sb_set: got %0b expected 1", chk_busy1); end
    nchecks++; if (chk_busy2 !== 1'b0) begin nerrors++; $display("[TB] FAIL sb_addr0: got %0b expected 0", chk_busy2); end
    s0_valid = 1'b1; s0_waddr = 5'd9; s0_wdata = 32'h9999_0009;
    @(posedge clk);
    #1;
    s0_valid = 1'b0;
    nchecks++; if (chk_busy1 !== 1'b1) begin nerrors++; $display("[TB] FAIL sb_busy_during_write: got %0b expected 1", chk_busy1); end
    @(posedge clk);
    #1;
    nchecks++; if (chk_busy1 !== 1'b0) begin nerrors++; $display("[TB] FAIL sb_clear: got %0b expected 0", chk_busy1); end
    s0_valid = 1'b1; s0_waddr = 5'd9; s0_wdata = 32'h9999_0019;
    @(posedge clk);
    #1;
    s0_valid  = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(posedge clk);
    #1;
    rsv_valid = 1'b0;
    nchecks++; if (chk_busy1 !== 1'b1) begin nerrors++; $display("[TB] FAIL sb_set_wins: got %0b expected 1", chk_busy1); end
    @(posedge clk);
    #1;
    nchecks++; if (chk_busy1 !== 1'b1) begin nerrors++; $display("[TB] FAIL sb_set_stays: got %0b expected 1", chk_busy1); end
    drive_idle();
  endtask
`else
  // Without the scoreboard, reservations never make anything busy.
  task test_scoreboard();
    apply_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    chk_addr1 = 5'd9; chk_addr2 = 5'd9;
    s0_valid  = 1'b1; s0_waddr = 5'd9; s0_wdata = 32'h9999_0009;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      s0_valid = 1'b0;
      nchecks++; if (chk_busy1 !== 1'b0) begin nerrors++; $display("[TB] FAIL nosb_busy1[%0d]: got %0b expected 0", k, chk_busy1); end
      nchecks++; if (chk_busy2 !== 1'b0) begin nerrors++; $display("[TB] FAIL nosb_busy2[%0d]: got %0b expected 0", k, chk_busy2); end
    end
    drive_idle();
  endtask
`endif

  // Random traffic against a transaction-level model: each requester holds
  // a pending write until granted; grants follow the arbitration rules.
  task test_random();
    logic        pv [2];
    logic [4:0]  pa [2];
    logic [31:0] pd [2];
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] bm;
    logic        eb1;
    logic        eb2;
    int          ptr;
    int          g;
    int          streak0;
    int          streak1;
    apply_reset();
    ptr = 0; ew = 1'b0; ea = 5'd0; ed = 32'd0; bm = 32'd0;
    streak0 = 0; streak1 = 0;
    for (int n = 0; n < 2; n++) begin pv[n] = 1'b0; pa[n] = 5'd0; pd[n] = 32'd0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && ($urandom_range(0, 9) < 7)) begin
          pv[n] = 1'b1;
          pa[n] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
          pd[n] = $urandom;
        end
      end
      s0_valid  = pv[0]; s0_waddr = pa[0]; s0_wdata = pd[0];
      s1_valid  = pv[1]; s1_waddr = pa[1]; s1_wdata = pd[1];
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'($urandom_range(0, 15));
      chk_addr1 = 5'($urandom_range(0, 15));
      chk_addr2 = 5'($urandom_range(0, 15));
      if (pv[0] && pv[1]) g = ptr;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
      else                g = -1;
`ifdef RF_SCOREBOARD_EN
      eb1 = (chk_addr1 != 5'd0) && bm[chk_addr1];
      eb2 = (chk_addr2 != 5'd0) && bm[chk_addr2];
`else
      eb1 = 1'b0;
      eb2 = 1'b0;
`endif
      @(negedge clk);
      nchecks++; if (s0_ready !== (g == 0)) begin nerrors++; $display("[TB] FAIL rand_s0_ready@%0d: got %0b expected %0b", cyc, s0_ready, g == 0); end
      nchecks++; if (s1_ready !== (g == 1)) begin nerrors++; $display("[TB] FAIL rand_s1_ready@%0d: got %0b expected %0b", cyc, s1_ready, g == 1); end
      nchecks++; if (chk_busy1 !== eb1) begin nerrors++; $display("[TB] FAIL rand_chk_busy1@%0d: got %0b expected %0b", cyc, chk_busy1, eb1); end
      nchecks++; if (chk_busy2 !== eb2) begin nerrors++; $display("[TB] FAIL rand_chk_busy2@%0d: got %0b expected %0b", cyc, chk_busy2, eb2); end
      if (pv[0] && pv[1]) begin
        streak0 = (s0_ready === 1'b1) ? 0 : streak0 + 1;
        streak1 = (s1_ready === 1'b1) ? 0 : streak1 + 1;
      end else begin
        streak0 = 0;
        streak1 = 0;
      end
      nchecks++; if ((streak0 > 1) || (streak1 > 1)) begin nerrors++; $display("[TB] FAIL rand_starvation@%0d: got streaks %0d/%0d expected at most 1", cyc, streak0, streak1); end
      @(posedge clk);
      #1;
`ifdef RF_SCOREBOARD_EN
      if (ew) bm[ea] = 1'b0;
      if (rsv_valid && (rsv_addr != 5'd0)) bm[rsv_addr] = 1'b1;
`endif
      if (g >= 0) begin
        if (pv[0] && pv[1]) ptr = 1 - ptr;
        if (pa[g] != 5'd0) begin
          ew = 1'b1; ea = pa[g]; ed = pd[g];
        end else begin
          ew = 1'b0;
        end
        pv[g] = 1'b0;
      end else begin
        ew = 1'b0;
      end
      nchecks++; if (rf_wen !== ew) begin nerrors++; $display("[TB] FAIL rand_rf_wen@%0d: got %0b expected %0b", cyc, rf_wen, ew); end
      nchecks++; if (rf_waddr !== ea) begin nerrors++; $display("[TB] FAIL rand_rf_waddr@%0d: got %0h expected %0h", cyc, rf_waddr, ea); end
      nchecks++; if (rf_wdata !== ed) begin nerrors++; $display("[TB] FAIL rand_rf_wdata@%0d: got %0h expected %0h", cyc, rf_wdata, ed); end
    end
    drive_idle();
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_reg0();
    test_mid_reset();
    test_scoreboard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
